// File: rtl/stream_sum_arbiter.sv
// stream_sum_arbiter
//   Shares a single stream-reduction engine among N requesters. Whole packets
//   are granted round-robin; the owner's beats are passed straight through to
//   the engine, and the engine's single result is routed back to that owner.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/data/last/ready   per-requester beat streams (lane i data at [i*W +: W])
//   res_valid/res_ready         per-requester result handshake (res_valid one-hot)
//   res_data                    shared result data (0 outside RESULT)
//   eng_in_*                    beat stream towards the engine
//   eng_res_*                   result stream from the engine
//   grant                       one-hot current owner, 0 when idle
//   busy                        high while a packet is in flight (STREAM or RESULT)
//   beat_count                  beats accepted in the current/last packet (saturating)
module stream_sum_arbiter #(
   parameter int N  = 4,
   parameter int W  = 32,
   parameter int CW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_valid,
   input  logic [N*W-1:0] req_data,
   input  logic [N-1:0]   req_last,
   output logic [N-1:0]   req_ready,
   output logic [N-1:0]   res_valid,
   output logic [W-1:0]   res_data,
   input  logic [N-1:0]   res_ready,
   output logic           eng_in_valid,
   output logic [W-1:0]   eng_in_data,
   output logic           eng_in_last,
   input  logic           eng_in_ready,
   input  logic           eng_res_valid,
   input  logic [W-1:0]   eng_res_data,
   output logic           eng_res_ready,
   output logic [N-1:0]   grant,
   output logic           busy,
   output logic [CW-1:0]  beat_count
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_RESULT = 2'd2;

   logic [1:0]    state;
   logic [PW-1:0] ptr;     // highest-priority requester for the next grant
   logic [PW-1:0] owner;   // binary index of the granted requester

   logic          sel_found;
   logic [PW-1:0] sel_idx;
   logic          in_xfer;
   logic          res_xfer;

   // Round-robin search starting at ptr and wrapping modulo N.
   always_comb begin
      int idx;
      // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!sel_found && req_valid[idx]) begin
            sel_found = 1'b1;
            sel_idx   = PW'(idx);
         end
      end
   end

   // Pass-through steering: only the owning state connects the owner's lane.
   always_comb begin
      req_ready     = '0;
      res_valid     = '0;
      res_data      = '0;
      eng_in_valid  = 1'b0;
      eng_in_data   = '0;
      eng_in_last   = 1'b0;
      eng_res_ready = 1'b0;
      if (state == S_STREAM) begin
         eng_in_valid     = req_valid[owner];
         eng_in_data      = req_data[owner*W +: W];
         eng_in_last      = req_last[owner];
         req_ready[owner] = eng_in_ready;
      end else if (state == S_RESULT) begin
         res_valid[owner] = eng_res_valid;
         res_data         = eng_res_data;
         eng_res_ready    = res_ready[owner];
      end
   end

   assign in_xfer  = (state == S_STREAM) && req_valid[owner] && eng_in_ready;
   assign res_xfer = (state == S_RESULT) && eng_res_valid && res_ready[owner];
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) begin
         state      <= S_IDLE;
         grant      <= '0;
         ptr        <= '0;
         owner      <= '0;
         beat_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (sel_found) begin
                  state      <= S_STREAM;
                  owner      <= sel_idx;
                  grant      <= {{(N-1){1'b0}}, 1'b1} << sel_idx;
                  beat_count <= '0;
               end
            end
            S_STREAM: begin
               if (in_xfer) begin
                  if (beat_count != '1)
                     beat_count <= beat_count + 1'b1;
                  if (req_last[owner])
                     state <= S_RESULT;
               end
            end
            S_RESULT: begin
               if (res_xfer) begin
                  state <= S_IDLE;
                  grant <= '0;
                  ptr   <= (owner == PW'(N-1)) ? '0 : owner + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_sum_arbiter.sv
// tb_stream_sum_arbiter
//   Directed bench: per-lane beat queues feed the requesters, a small summing
//   engine model answers each packet, and monitors log grants, engine beats
//   and delivered results for comparison against hand-computed values.
module tb_stream_sum_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int CW = 16;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   res_valid;
   logic [W-1:0]   res_data;
   logic [N-1:0]   res_ready = '1;
   logic           eng_in_valid;
   logic [W-1:0]   eng_in_data;
   logic           eng_in_last;
   logic           eng_in_ready;
   logic           eng_res_valid = 1'b0;
   logic [W-1:0]   eng_res_data = '0;
   logic           eng_res_ready;
   logic [N-1:0]   grant;
   logic           busy;
   logic [CW-1:0]  beat_count;

   stream_sum_arbiter #(.N(N), .W(W), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .eng_in_valid(eng_in_valid), .eng_in_data(eng_in_data), .eng_in_last(eng_in_last),
      .eng_in_ready(eng_in_ready),
      .eng_res_valid(eng_res_valid), .eng_res_data(eng_res_data), .eng_res_ready(eng_res_ready),
      .grant(grant), .busy(busy), .beat_count(beat_count)
   );

   always #5 clk = ~clk;

   // Lane producers: each lane presents the head of its beat queue.
   logic [W:0] lane_mem [N][64];
   int         lane_wr [N];
   int         lane_rd [N];

   always_comb begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      for (int i = 0; i < N; i++) begin
         if (lane_rd[i] != lane_wr[i]) begin
            req_valid[i]        = 1'b1;
            req_data[i*W +: W]  = lane_mem[i][lane_rd[i] % 64][W-1:0];
            req_last[i]         = lane_mem[i][lane_rd[i] % 64][W];
         end
      end
   end

   // Engine backpressure: when enabled, ready toggles every cycle.
   logic eng_bp = 1'b0;
   logic tog = 1'b0;
   assign eng_in_ready = !eng_bp || tog;

   // Logs written by the monitor, read by the stimulus.
   logic [W-1:0] eng_d [256];
   logic         eng_l [256];
   int           eng_n = 0;
   logic [N-1:0] res_vec [64];
   logic [W-1:0] res_val [64];
   int           res_n = 0;
   logic [N-1:0] gnt_vec [64];
   int           gnt_n = 0;
   logic [N-1:0] prev_grant = '0;
   logic [W-1:0] eng_acc = '0;

   initial begin
      for (int i = 0; i < N; i++) begin
         lane_wr[i] = 0;
         lane_rd[i] = 0;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) lane_rd[i] <= lane_wr[i];
         eng_acc       <= '0;
         eng_res_valid <= 1'b0;
         eng_res_data  <= '0;
      end else begin
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) lane_rd[i] <= lane_rd[i] + 1;
         if (eng_in_valid && eng_in_ready) begin
            eng_d[eng_n % 256] <= eng_in_data;
            eng_l[eng_n % 256] <= eng_in_last;
            eng_n <= eng_n + 1;
            if (eng_in_last) begin
               eng_res_valid <= 1'b1;
               eng_res_data  <= eng_acc + eng_in_data;
               eng_acc       <= '0;
            end else begin
               eng_acc <= eng_acc + eng_in_data;
            end
         end
         if (eng_res_valid && eng_res_ready) eng_res_valid <= 1'b0;
         if (|(res_valid & res_ready)) begin
            res_vec[res_n % 64] <= res_valid;
            res_val[res_n % 64] <= res_data;
            res_n <= res_n + 1;
         end
         if (grant != '0 && prev_grant == '0) begin
            gnt_vec[gnt_n % 64] <= grant;
            gnt_n <= gnt_n + 1;
         end
      end
      prev_grant <= grant;
      tog        <= ~tog;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic push(input int lane, input logic [W-1:0] data, input logic last);
      lane_mem[lane][lane_wr[lane] % 64] = {last, data};
      lane_wr[lane] = lane_wr[lane] + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_res(input int target);
      int cyc = 0;
      while (res_n < target && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      check("result_timeout", res_n, target);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_beat_count"}, beat_count, 0);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_eng_in_valid"}, eng_in_valid, 0);
      check({tag, "_eng_res_ready"}, eng_res_ready, 0);
      check({tag, "_res_data"}, res_data, 0);
   endtask

   initial begin
      int b, r, g, cyc;

      // Reset state, sampled while rst is still high after a clock edge.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      rst = 1'b0;

      // Single packet on lane 0: 1,2,3 -> 6.
      do_reset();
      b = eng_n; r = res_n; g = gnt_n;
      push(0, 1, 1'b0); push(0, 2, 1'b0); push(0, 3, 1'b1);
      wait_res(r + 1);
      check("single_beats", eng_n - b, 3);
      check("single_d0", eng_d[b], 1);
      check("single_d1", eng_d[b+1], 2);
      check("single_d2", eng_d[b+2], 3);
      check("single_l0", eng_l[b], 0);
      check("single_l1", eng_l[b+1], 0);
      check("single_l2", eng_l[b+2], 1);
      check("single_gnt", gnt_vec[g], 4'b0001);
      check("single_res_vec", res_vec[r], 4'b0001);
      check("single_res_val", res_val[r], 6);
      check("single_beat_count", beat_count, 3);
      check("single_grant_idle", grant, 0);
      check("single_busy_idle", busy, 0);

      // Simultaneous one-beat packets on lanes 1 and 2.
      do_reset();
      r = res_n; g = gnt_n;
      push(1, 5, 1'b1); push(2, 7, 1'b1);
      wait_res(r + 2);
      check("simul_gnt0", gnt_vec[g], 4'b0010);
      check("simul_gnt1", gnt_vec[g+1], 4'b0100);
      check("simul_res0_vec", res_vec[r], 4'b0010);
      check("simul_res0_val", res_val[r], 5);
      check("simul_res1_vec", res_vec[r+1], 4'b0100);
      check("simul_res1_val", res_val[r+1], 7);
      check("simul_beat_count", beat_count, 1);

      // Fairness: all lanes hold two 2-beat packets each.
      do_reset();
      r = res_n; g = gnt_n;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) begin
            push(i, 100*i + 10*p + 1, 1'b0);
            push(i, 100*i + 10*p + 2, 1'b1);
         end
      wait_res(r + 8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("fair_gnt%0d", k), gnt_vec[g+k], 32'(1) << (k % 4));
         check($sformatf("fair_res_vec%0d", k), res_vec[r+k], 32'(1) << (k % 4));
         check($sformatf("fair_res_val%0d", k), res_val[r+k], 2*(100*(k % 4) + 10*(k / 4)) + 3);
      end

      // Engine input backpressure on lane 3.
      do_reset();
      b = eng_n; r = res_n;
      eng_bp = 1'b1;
      push(3, 10, 1'b0); push(3, 20, 1'b0); push(3, 30, 1'b0); push(3, 40, 1'b1);
      cyc = 0;
      while (!grant[3] && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("bp_granted", grant, 4'b1000);
      while (eng_n - b < 4 && cyc < 100) begin
         check("bp_ready_mirror", req_ready[3], eng_in_ready);
         check("bp_ready_others", req_ready[2:0], 0);
         @(negedge clk);
         cyc++;
      end
      wait_res(r + 1);
      eng_bp = 1'b0;
      check("bp_beats", eng_n - b, 4);
      check("bp_d0", eng_d[b], 10);
      check("bp_d1", eng_d[b+1], 20);
      check("bp_d2", eng_d[b+2], 30);
      check("bp_d3", eng_d[b+3], 40);
      check("bp_l3", eng_l[b+3], 1);
      check("bp_res_vec", res_vec[r], 4'b1000);
      check("bp_res_val", res_val[r], 100);
      check("bp_beat_count", beat_count, 4);

      // Result backpressure: lane 0 holds off its result while lane 1 waits.
      do_reset();
      r = res_n; g = gnt_n;
      res_ready = 4'b1110;
      push(0, 42, 1'b1); push(1, 9, 1'b1);
      cyc = 0;
      while (!res_valid[0] && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      for (int k = 0; k < 5; k++) begin
         check("rbp_eng_res_ready", eng_res_ready, 0);
         check("rbp_res_valid", res_valid, 4'b0001);
         check("rbp_res_data", res_data, 42);
         check("rbp_grant", grant, 4'b0001);
         @(negedge clk);
      end
      res_ready = 4'b1111;
      wait_res(r + 2);
      check("rbp_gnt0", gnt_vec[g], 4'b0001);
      check("rbp_gnt1", gnt_vec[g+1], 4'b0010);
      check("rbp_res0_val", res_val[r], 42);
      check("rbp_res1_vec", res_vec[r+1], 4'b0010);
      check("rbp_res1_val", res_val[r+1], 9);

      // Reset mid-packet after 2 of 4 beats on lane 1.
      do_reset();
      b = eng_n; r = res_n; g = gnt_n;
      push(1, 1, 1'b0); push(1, 2, 1'b0); push(1, 3, 1'b0); push(1, 4, 1'b1);
      cyc = 0;
      while (eng_n - b < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_beat_count_before", beat_count, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_quiet("abort");
      push(2, 77, 1'b1);
      wait_res(r + 1);
      check("abort_new_gnt", gnt_vec[g+1], 4'b0100);
      check("abort_new_res_vec", res_vec[r], 4'b0100);
      check("abort_new_res_val", res_val[r], 77);
      check("abort_engine_beats", eng_n - b, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
